// File: rtl/mem_access_pkg.sv
// mem_access_pkg: shared definitions for the load/store front-end.
//   SZ_*            request size encodings (req_size)
//   state_t         controller FSM states
//   is_misaligned() 1 when a size/low-address pair cannot be served as one access
//   align_lo()      forces the low address bits to the natural alignment of a size
package mem_access_pkg;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;
   localparam logic [1:0] SZ_ILL  = 2'b11;

   typedef enum logic [2:0] {
      S_IDLE,
      S_RD,
      S_CAP,
      S_WR,
      S_RESP
   } state_t;

   function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
      logic mis;
      case (size)
         SZ_BYTE: mis = 1'b0;
         SZ_HALF: mis = lo[0];
         SZ_WORD: mis = (lo != 2'b00);
         default: mis = 1'b1;
      endcase
      return mis;
   endfunction

   // An illegal size is served as a word when misalignment is not an error.
   function automatic logic [1:0] align_lo(input logic [1:0] size, input logic [1:0] lo);
      logic [1:0] a;
      case (size)
         SZ_BYTE: a = lo;
         SZ_HALF: a = {lo[1], 1'b0};
         default: a = 2'b00;
      endcase
      return a;
   endfunction

endpackage

// File: rtl/mem_lane_unit.sv
// mem_lane_unit: combinational lane handling for sub-word accesses (little-endian).
//   word       in  32  word read from the RAM
//   addr_lo    in  2   byte offset within the word (already aligned to size)
//   size       in  2   access size (SZ_*); SZ_ILL behaves as a word
//   sign_ext   in  1   1 = sign-extend loads, 0 = zero-extend
//   wdata      in  32  right-justified store data
//   load_data  out 32  extracted and extended load value
//   store_word out 32  word with the store data merged into its lane
module mem_lane_unit
   import mem_access_pkg::*;
(
   input  logic [31:0] word,
   input  logic [1:0]  addr_lo,
   input  logic [1:0]  size,
   input  logic        sign_ext,
   input  logic [31:0] wdata,
   output logic [31:0] load_data,
   output logic [31:0] store_word
);

   logic [7:0]  lane_b;
   logic [15:0] lane_h;

   always_comb begin
      lane_b = word[7:0];
      case (addr_lo)
         2'd0: lane_b = word[7:0];
         2'd1: lane_b = word[15:8];
         2'd2: lane_b = word[23:16];
         2'd3: lane_b = word[31:24];
         default: lane_b = word[7:0];
      endcase
      lane_h = addr_lo[1] ? word[31:16] : word[15:0];

      load_data  = word;
      store_word = wdata;
      case (size)
         SZ_BYTE: begin
            load_data = {{24{sign_ext & lane_b[7]}}, lane_b};
            case (addr_lo)
               2'd0: store_word = {word[31:8], wdata[7:0]};
               2'd1: store_word = {word[31:16], wdata[7:0], word[7:0]};
               2'd2: store_word = {word[31:24], wdata[7:0], word[15:0]};
               2'd3: store_word = {wdata[7:0], word[23:0]};
               default: store_word = word;
            endcase
         end
         SZ_HALF: begin
            load_data  = {{16{sign_ext & lane_h[15]}}, lane_h};
            store_word = addr_lo[1] ? {wdata[15:0], word[15:0]} : {word[31:16], wdata[15:0]};
         end
         default: begin
            load_data  = word;
            store_word = wdata;
         end
      endcase
   end

endmodule

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: load/store front-end for a single-port synchronous word RAM.
// Serves byte/half/word requests with full-word RAM cycles; sub-word stores use
// read-modify-write. One request in flight; response held until consumed.
// Optional build macro MEM_ACCESS_PERF_EN adds perf_loads/perf_stores/perf_errs.
//
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   req_valid/req_ready         request handshake
//   req_we/size/signed/addr/wdata  request fields, captured at acceptance
//   resp_valid/resp_ready       response handshake
//   resp_rdata, resp_err        extended load data (0 for stores/errors), error flag
//   mem_cs/oe/we/addr/din       RAM controls (word-aligned), mem_dout RAM read data
//
// state  | meaning
// IDLE   | waiting for a request (req_ready=1)
// RD     | RAM read cycle (cs, oe)
// CAP    | sample mem_dout: extract load lane or merge store lane
// WR     | RAM write cycle (cs, we)
// RESP   | response presented until resp_ready
module mem_access_ctrl
   import mem_access_pkg::*;
#(
   parameter int ADDR_W          = 32,
   parameter bit ERR_ON_MISALIGN = 1'b1
) (
   input  logic              clk,
   input  logic              rst_n,
`ifdef MEM_ACCESS_PERF_EN
   output logic [31:0]       perf_loads,
   output logic [31:0]       perf_stores,
   output logic [31:0]       perf_errs,
`endif
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [1:0]        req_size,
   input  logic              req_signed,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [31:0]       resp_rdata,
   output logic              resp_err,
   output logic              mem_cs,
   output logic              mem_oe,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_din,
   input  logic [31:0]       mem_dout
);

   state_t      state_q, state_d;
   logic        run_q;
   logic [1:0]  size_q;
   logic        sign_q;
   logic        we_q;
   logic [1:0]  lo_q;
   logic [31:0] wdata_q;
   logic [31:0] rdata_q;
   logic        err_q;

   logic        accept;
   logic        mis_err;
   logic        resp_done;
   logic [31:0] lane_load;
   logic [31:0] lane_store;

   // run_q keeps req_ready low while reset is held and for the release edge.
   assign req_ready  = run_q & (state_q == S_IDLE);
   assign accept     = req_valid & req_ready;
   assign mis_err    = ERR_ON_MISALIGN & is_misaligned(req_size, req_addr[1:0]);
   assign resp_valid = (state_q == S_RESP);
   assign resp_done  = resp_valid & resp_ready;
   assign resp_rdata = rdata_q;
   assign resp_err   = err_q;
   assign mem_cs     = (state_q == S_RD) | (state_q == S_WR);
   assign mem_oe     = (state_q == S_RD);
   assign mem_we     = (state_q == S_WR);

   mem_lane_unit u_lane (
      .word       (mem_dout),
      .addr_lo    (lo_q),
      .size       (size_q),
      .sign_ext   (sign_q),
      .wdata      (wdata_q),
      .load_data  (lane_load),
      .store_word (lane_store)
   );

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               if (mis_err)
                  state_d = S_RESP;
               else if (req_we && req_size[1])
                  state_d = S_WR;        // word (or force-aligned illegal) store
               else
                  state_d = S_RD;
            end
         end
         S_RD:    state_d = S_CAP;
         S_CAP:   state_d = we_q ? S_WR : S_RESP;
         S_WR:    state_d = S_RESP;
         S_RESP:  if (resp_ready) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         run_q    <= 1'b0;
         size_q   <= SZ_BYTE;
         sign_q   <= 1'b0;
         we_q     <= 1'b0;
         lo_q     <= 2'b00;
         wdata_q  <= '0;
         rdata_q  <= '0;
         err_q    <= 1'b0;
         mem_addr <= '0;
         mem_din  <= '0;
      end else begin
         state_q <= state_d;
         run_q   <= 1'b1;
         case (state_q)
            S_IDLE: begin
               if (accept) begin
                  size_q  <= req_size;
                  sign_q  <= req_signed;
                  we_q    <= req_we;
                  lo_q    <= align_lo(req_size, req_addr[1:0]);
                  wdata_q <= req_wdata;
                  rdata_q <= '0;
                  err_q   <= mis_err;
                  if (!mis_err) begin
                     mem_addr <= {req_addr[ADDR_W-1:2], 2'b00};
                     if (req_we)
                        mem_din <= req_wdata;
                  end
               end
            end
            S_CAP: begin
               if (we_q)
                  mem_din <= lane_store;
               else
                  rdata_q <= lane_load;
            end
            S_RESP: begin
               if (resp_ready) begin
                  rdata_q <= '0;
                  err_q   <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

`ifdef MEM_ACCESS_PERF_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_loads  <= '0;
         perf_stores <= '0;
         perf_errs   <= '0;
      end else if (resp_done) begin
         if (err_q)
            perf_errs <= perf_errs + 32'd1;
         else if (we_q)
            perf_stores <= perf_stores + 32'd1;
         else
            perf_loads <= perf_loads + 32'd1;
      end
   end
`endif

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Load/store front-end sitting directly upstream of the single-port synchronous data RAM (syncram).
- Accepts one byte/half/word request at a time from the pipeline over a valid/ready handshake.
- Issues only word-aligned, full-word RAM cycles; the RAM's sb/sh/lb/lh pins are tied 0 at top level.
- Does lane extraction and sign/zero extension for loads, and read-modify-write for sub-word stores; returns data/error over a valid/ready response channel.

Parameters:
- ADDR_W, 32, request and RAM address width.
- ERR_ON_MISALIGN, 1, 1 = misaligned request completes with resp_err and no RAM access; 0 = low address bits are force-aligned and the access proceeds.

Ports:
- clk  in  1  clock, all state updates on posedge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal (treated as misaligned).
- req_signed  in  1  loads only: 1 = sign-extend, 0 = zero-extend.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data, right-justified.
- resp_valid  out  1  response present.
- resp_ready  in  1  consumer accepts response.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- resp_err  out  1  misaligned or illegal size.
- mem_cs  out  1  RAM chip select.
- mem_oe  out  1  RAM read enable.
- mem_we  out  1  RAM write enable.
- mem_addr  out  ADDR_W  {addr[ADDR_W-1:2], 2'b00}.
- mem_din  out  32  RAM write data.
- mem_dout  in  32  RAM read data, valid the cycle after the mem_oe edge.

Behaviour:
- Reset (async, rst_n=0): state IDLE.
  - req_ready=0 while in reset, 1 in IDLE after release.
  - resp_valid=0, resp_err=0, resp_rdata=0.
  - mem_cs/oe/we=0, mem_addr=0, mem_din=0; all captured registers cleared.
- Reset mid-operation aborts immediately. A WR whose edge has not occurred performs no write. No response is produced.
- FSM states: IDLE, RD, CAP, WR, RESP.
- Memory outputs are decoded from registered state:
  - RD: cs=1, oe=1.
  - WR: cs=1, we=1.
  - Otherwise cs/oe/we=0.
- req_ready = (state==IDLE). Acceptance is req_valid & req_ready; addr, size, signed, we and wdata are captured at that edge.
- Misalignment: half with addr[0]=1, word with addr[1:0]!=0, or size 11.
  - With ERR_ON_MISALIGN=1: IDLE -> RESP with err=1, no RAM cycle.
- Load: IDLE -> RD -> CAP -> RESP.
  - CAP samples mem_dout and extracts the lane little-endian: byte lane addr[1:0], half lane addr[1].
  - Extends per req_signed.
  - resp_valid rises 3 cycles after acceptance.
- Word store: IDLE -> WR -> RESP. mem_din = wdata. resp_valid rises 2 cycles after acceptance.
- Sub-word store: IDLE -> RD -> CAP -> WR -> RESP.
  - CAP merges wdata[7:0] or wdata[15:0] into the read word at the target lane; the other bytes are unchanged.
  - resp_valid rises 4 cycles after acceptance.
- RESP: resp_valid, resp_rdata and resp_err are held stable until resp_ready=1, then -> IDLE.
  - A new request is accepted no earlier than the cycle after the response handshake (no overlap).
- mem_addr is held at the captured aligned address from RD through WR; held unchanged elsewhere.
- Address wrap: none; the full ADDR_W address is passed through aligned.

Optional Feature:
- MEM_ACCESS_PERF_EN defined adds three output ports:
  - perf_loads [31:0]: increments on each completed non-error load response handshake.
  - perf_stores [31:0]: same, for stores.
  - perf_errs [31:0]: increments on each error response.
  - All three wrap at 2^32 and clear on reset.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package mem_access_pkg holds:
  - Size encodings SZ_BYTE/SZ_HALF/SZ_WORD.
  - FSM state enum.
  - Function is_misaligned(size, addr[1:0]).
- One combinational sub-module, mem_lane_unit:
  - Inputs: word, addr[1:0], size, signed, wdata.
  - Outputs: extended load data and merged store word.
- The FSM stays in mem_access_ctrl.

Test Plan:
- Reset mid-RMW: assert rst_n=0 during CAP of a sub-word store -> RAM word unchanged, outputs zero, req_ready=1 after release.
- Word store then word load:
  - Store 0x00000010 <- 0xDEADBEEF, then load 0x10 signed.
  - Required: one mem_we pulse with mem_din=0xDEADBEEF; resp_rdata=0xDEADBEEF 3 cycles after load acceptance.
- Byte RMW:
  - RAM[0x10]=0x11223344; store byte 0xAB at 0x12.
  - Required: RD then WR with mem_din=0x11AB3344; load byte 0x12 signed -> 0xFFFFFFAB; unsigned -> 0x000000AB.
- Half load: RAM[0x20]=0x8001_7FFF.
  - Half at 0x22 signed -> 0xFFFF8001.
  - Half at 0x20 signed -> 0x00007FFF.
- Misaligned (ERR_ON_MISALIGN=1):
  - Word load at 0x13 -> resp_err=1, resp_rdata=0, mem_cs never asserted.
  - Size 11 -> resp_err=1.
- Backpressure: hold resp_ready=0 for 5 cycles -> resp_valid/rdata stable, req_ready=0, no extra RAM cycles.
  - With MEM_ACCESS_PERF_EN: the counters match the handshake counts.
